// File: rtl/piece_bag_generator.sv
// piece_bag_generator
//   7-bag polyomino piece source. A four-phase req/ack handshake returns a
//   4x4 piece bitmap and its ID. Draws come from a free-running 16-bit
//   Galois LFSR. A used-piece mask guarantees no repeat until all seven
//   pieces have been handed out.
//
// Ports
//   Clk           system clock
//   Reset         asynchronous, active-high
//   seed_load     load LFSR from seed (zero seed substitutes LFSR_SEED)
//   seed[15:0]    seed value
//   req           piece request (four-phase, level-sensitive)
//   ack           piece valid / request acknowledged
//   piece[15:0]   4x4 bitmap, row-major, bit 15 = row 0 col 0
//   piece_id[2:0] drawn piece ID
//   busy          FSM not idle
//   bag_remaining unused pieces left in the current bag (7..1)
module piece_bag_generator #(
  parameter int unsigned NUM_PIECES = 7,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req,
  output logic        ack,
  output logic [15:0] piece,
  output logic [2:0]  piece_id,
  output logic        busy,
  output logic [2:0]  bag_remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    CHECK = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                  state;
  logic [15:0]             lfsr;
  logic [2:0]              cand;
  logic [NUM_PIECES-1:0]   mask;

  logic [15:0]             lfsr_next;
  logic [15:0]             rom_word;
  logic [NUM_PIECES-1:0]   marked;
  logic                    bag_full;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    rom_word = 16'h0000;
    case (cand)
      3'd0:    rom_word = 16'h0F00; // I
      3'd1:    rom_word = 16'h6600; // O
      3'd2:    rom_word = 16'h4E00; // T
      3'd3:    rom_word = 16'h6C00; // S
      3'd4:    rom_word = 16'hC600; // Z
      3'd5:    rom_word = 16'h8E00; // J
      3'd6:    rom_word = 16'h2E00; // L
      default: rom_word = 16'h0000;
    endcase
  end

  // Mask as it would look after marking cand; a full bag refills at once.
  always_comb begin
    marked = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      marked[i] = mask[i] | (cand == 3'(i));
    end
    bag_full = &marked;
  end

  // LFSR free-runs regardless of FSM state; a load overrides the advance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cand          <= '0;
      mask          <= '0;
      ack           <= 1'b0;
      busy          <= 1'b0;
      piece         <= '0;
      piece_id      <= '0;
      bag_remaining <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= PICK;
            busy  <= 1'b1;
          end
        end
        PICK: begin
          cand  <= (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
          state <= CHECK;
        end
        CHECK: begin
          if (mask[cand]) begin
            cand <= (cand == 3'd6) ? 3'd0 : cand + 3'd1;
          end else begin
            piece    <= rom_word;
            piece_id <= cand;
            ack      <= 1'b1;
            state    <= ACK;
            // Tracking the count alongside the mask equals 7 - popcount(mask).
            if (bag_full) begin
              mask          <= '0;
              bag_remaining <= 3'd7;
            end else begin
              mask          <= marked;
              bag_remaining <= bag_remaining - 3'd1;
            end
          end
        end
        ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_bag_generator.sv
module tb_piece_bag_generator;

  logic        Clk;
  logic        Reset;
  logic        seed_load;
  logic [15:0] seed;
  logic        req;
  logic        ack;
  logic [15:0] piece;
  logic [2:0]  piece_id;
  logic        busy;
  logic [2:0]  bag_remaining;

  piece_bag_generator #(
    .NUM_PIECES (7),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .seed_load     (seed_load),
    .seed          (seed),
    .req           (req),
    .ack           (ack),
    .piece         (piece),
    .piece_id      (piece_id),
    .busy          (busy),
    .bag_remaining (bag_remaining)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          rst_before;
    logic [15:0] seed;
    int          hold;
    logic [2:0]  id;
    logic [15:0] pc;
    logic [2:0]  rem;
    int          lat;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rom(input logic [2:0] id);
    case (id)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h6600;
      3'd2:    return 16'h4E00;
      3'd3:    return 16'h6C00;
      3'd4:    return 16'hC600;
      3'd5:    return 16'h8E00;
      3'd6:    return 16'h2E00;
      default: return 16'hXXXX;
    endcase
  endfunction

  task automatic do_reset();
    req       = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    Reset     = 1'b1;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  // One full handshake. While req is held after ack, outputs are checked
  // against e when known is set.
  task automatic run_draw(input bit use_seed, input logic [15:0] s, input int hold,
                          input bit known, input vec_t e,
                          output logic [2:0] id, output logic [15:0] pc,
                          output logic [2:0] rem, output int lat);
    req       = 1'b1;
    seed_load = use_seed;
    seed      = s;
    step();
    seed_load = 1'b0;
    seed      = '0;
    check("busy_after_req", 32'(busy), 32'd1);
    lat = 0;
    while (ack !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    if (ack !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", lat);
    end
    id  = piece_id;
    pc  = piece;
    rem = bag_remaining;
    for (int c = 0; c < hold; c++) begin
      step();
      check("hold_ack", 32'(ack), 32'd1);
      if (known) begin
        check("hold_piece", 32'(piece), 32'(e.pc));
        check("hold_rem", 32'(bag_remaining), 32'(e.rem));
      end
    end
    req = 1'b0;
    step();
    check("ack_fall", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    logic [2:0]  id;
    logic [15:0] pc;
    logic [2:0]  rem;
    int          lat;
    vec_t        e;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].rst_before) do_reset();
      sb.push_back(tbl[i]);
      run_draw(1'b1, tbl[i].seed, tbl[i].hold, 1'b1, tbl[i], id, pc, rem, lat);
      e = sb.pop_front();
      check($sformatf("row%0d_id", i), 32'(id), 32'(e.id));
      check($sformatf("row%0d_piece", i), 32'(pc), 32'(e.pc));
      check($sformatf("row%0d_rem", i), 32'(rem), 32'(e.rem));
      check($sformatf("row%0d_lat", i), 32'(lat), 32'(e.lat));
    end
  endtask

  initial begin
    logic [2:0]  id;
    logic [15:0] pc;
    logic [2:0]  rem;
    int          lat;
    logic [7:0]  seen;
    logic [2:0]  exp_rem [8];
    int          ack_count;
    vec_t        dummy;

    //               rst   seed      hold id    piece      rem   lat
    tbl[0] = '{1'b1, 16'hACE1, 0,  3'd1, 16'h6600, 3'd6, 2}; // seeded draw
    tbl[1] = '{1'b0, 16'hACE1, 0,  3'd2, 16'h4E00, 3'd5, 3}; // one scan step
    tbl[2] = '{1'b0, 16'h0000, 0,  3'd3, 16'h6C00, 3'd4, 4}; // zero seed, two steps
    tbl[3] = '{1'b0, 16'h0007, 0,  3'd0, 16'h0F00, 3'd3, 2}; // 7 maps to 0
    tbl[4] = '{1'b0, 16'h0006, 0,  3'd6, 16'h2E00, 3'd2, 2};
    tbl[5] = '{1'b0, 16'h0005, 0,  3'd5, 16'h8E00, 3'd1, 2};
    tbl[6] = '{1'b0, 16'h0006, 0,  3'd4, 16'hC600, 3'd7, 7}; // wrap 6->0, refill
    tbl[7] = '{1'b0, 16'h1234, 20, 3'd4, 16'hC600, 3'd6, 2}; // fresh bag, held req
    tbl[8] = '{1'b1, 16'h0000, 0,  3'd1, 16'h6600, 3'd6, 2}; // zero seed from reset
    exp_rem = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7, 3'd6};
    dummy = tbl[0];

    req       = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    Reset     = 1'b1;
    #2;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_piece", 32'(piece), 32'd0);
    check("rst_id", 32'(piece_id), 32'd0);
    check("rst_rem", 32'(bag_remaining), 32'd7);
    step();
    Reset = 1'b0;
    step();

    apply_rows(0, 8);

    // Bag completeness with the free-running LFSR
    do_reset();
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      run_draw(1'b0, 16'h0000, 0, 1'b0, dummy, id, pc, rem, lat);
      if (i < 7) begin
        check("bag_unique", 32'(seen[id]), 32'd0);
        seen[id] = 1'b1;
      end
      check("bag_piece_rom", 32'(pc), 32'(rom(id)));
      check("bag_rem", 32'(rem), 32'(exp_rem[i]));
      check("bag_lat_range", 32'((lat >= 2) && (lat <= 8)), 32'd1);
    end
    check("bag_permutation", 32'(seen), 32'h7F);

    // req dropped before ack: single-cycle ack, then idle
    req = 1'b1;
    step();
    req = 1'b0;
    lat = 0;
    while (ack !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    check("early_drop_ack", 32'(ack), 32'd1);
    step();
    check("early_drop_ack_fall", 32'(ack), 32'd0);
    check("early_drop_busy", 32'(busy), 32'd0);
    ack_count = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack === 1'b1) ack_count++;
    end
    check("early_drop_no_redraw", 32'(ack_count), 32'd0);

    // Reset during a long collision scan
    apply_rows(0, 5);
    req       = 1'b1;
    seed_load = 1'b1;
    seed      = 16'h0006;
    step();
    seed_load = 1'b0;
    seed      = '0;
    step();
    step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("midscan_ack", 32'(ack), 32'd0);
    check("midscan_busy", 32'(busy), 32'd0);
    check("midscan_piece", 32'(piece), 32'd0);
    check("midscan_rem", 32'(bag_remaining), 32'd7);
    req = 1'b0;
    step();
    Reset = 1'b0;
    ack_count = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ack === 1'b1) ack_count++;
    end
    check("midscan_no_ack", 32'(ack_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piece_bag_generator.md
# piece_bag_generator

Hardware polyomino piece source for the game datapath. It answers the game logic's four-phase piece request with a 4x4 piece bitmap and piece ID. Pieces are drawn by a 7-bag randomizer, which yields no repeat until all seven pieces are used, and is driven by a free-running 16-bit LFSR. Software can reseed the LFSR from the random-noise PIO word.

## Interface
Parameters:
- NUM_PIECES, 7: bag size; piece IDs are 0..NUM_PIECES-1. Only 7 is supported.
- LFSR_SEED, 16'hACE1: LFSR value after reset, and the substitute for a zero seed.

Ports:
- Clk  in  1  system clock (50 MHz domain).
- Reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- seed_load  in  1  load LFSR from seed this cycle.
- seed  in  16  seed value (random-noise PIO word).
- req  in  1  piece request, four-phase, level-sensitive.
- ack  out  1  piece valid / request acknowledged.
- piece  out  16  4x4 bitmap, row-major; bit 15 = row 0 col 0, bit 12 = row 0 col 3.
- piece_id  out  3  drawn piece ID.
- busy  out  1  high whenever state != IDLE.
- bag_remaining  out  3  count of unused pieces in the current bag (7..1).

## Operation
- LFSR: Galois, lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0), advancing every cycle.
  - seed_load takes priority over advance: lfsr <= seed, or LFSR_SEED if seed == 0.
  - seed_load is accepted in any state and never disturbs the handshake.
- Bag: 7-bit used mask, one bit per ID.
  - bag_remaining = 7 - popcount(mask).
  - When marking a draw would set all 7 bits, the mask clears to 0 in that same cycle, so bag_remaining returns to 7.
- Piece ROM, by ID:
  - 0 I = 16'h0F00
  - 1 O = 16'h6600
  - 2 T = 16'h4E00
  - 3 S = 16'h6C00
  - 4 Z = 16'hC600
  - 5 J = 16'h8E00
  - 6 L = 16'h2E00
- FSM states:
  - IDLE: if req = 1, go to PICK.
  - PICK: cand <= lfsr[2:0], with 7 mapped to 0; go to CHECK.
  - CHECK: if mask[cand] = 1, cand <= (cand == 6) ? 0 : cand + 1 and stay in CHECK. Otherwise: piece <= ROM[cand], piece_id <= cand, mark cand (with refill rule), ack <= 1, go to ACK.
  - ACK: hold ack, piece and piece_id stable. When req = 0: ack <= 0, go to IDLE.
- piece and piece_id hold their last drawn value after ack falls, until the next draw.
- req dropped before ack (protocol violation): the draw completes anyway. ack is high for exactly one cycle, then the FSM returns to IDLE.
- req held high after ack: no second draw occurs until req is seen low in ACK and the FSM returns to IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - ack = 0, busy = 0, piece = 16'h0000, piece_id = 0
  - bag_remaining = 7, mask = 0, lfsr = LFSR_SEED, state = IDLE
- Reset is asynchronous: asserting it mid-draw clears all state and outputs immediately.
- Latency: req sampled high at edge N gives PICK at N, CHECK at N+1, and ack high after edge N+2+k, where k is the number of scan steps (0..6). Worst case is 8 cycles.
- ack falls on the edge after req is sampled low in ACK. The earliest next PICK is 2 edges after req rises again.
- bag_remaining updates on the same edge that ack rises.

## Test plan
- Seeded draw: assert seed_load = 1 with seed = 16'hACE1 and req = 1 together at edge N, after reset.
  - ack rises after N+2.
  - piece_id = 1, piece = 16'h6600, bag_remaining = 6.
- Collision scan: drop req, then repeat the same seed_load + req.
  - cand 1 is used, so exactly one scan step occurs.
  - ack rises after N+3 with piece_id = 2, piece = 16'h4E00, bag_remaining = 5.
- Bag completeness: from reset, perform 7 full handshakes.
  - IDs returned are a permutation of 0..6.
  - bag_remaining goes 6, 5, 4, 3, 2, 1, then 7 after the 7th draw.
  - The 8th draw starts a fresh bag.
- Four-phase hold: keep req high for 20 cycles after ack.
  - ack stays 1; piece and bag_remaining do not change.
  - Drop req: ack = 0 one cycle later and busy = 0.
- Zero seed: seed_load with seed = 0 → the LFSR internal value is 16'hACE1. The following draw matches the first scenario's result for the same bag state.
- Reset mid-scan: preload the mask with 6 pieces used and issue req; assert Reset during CHECK.
  - ack, busy and piece go to 0 immediately.
  - bag_remaining = 7.
  - No ack pulse after Reset is released.
